// File: rtl/wb_sysa_seq.sv
// ============================================================================
// wb_sysa_seq : Wishbone-mapped sequencer feeding an N x N systolic array
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_sysa_seq #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          N            = 3,
    parameter int          DW           = 8,
    parameter int          AW           = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                caravel_wb_clk_i,
    input  logic                caravel_wb_rst_n_i,
    input  logic                caravel_wb_stb_i,
    input  logic                caravel_wb_cyc_i,
    input  logic                caravel_wb_we_i,
    input  logic [3:0]          caravel_wb_sel_i,
    input  logic [31:0]         caravel_wb_adr_i,
    input  logic [31:0]         caravel_wb_dat_i,
    output logic                caravel_wb_ack_o,
    output logic [31:0]         caravel_wb_dat_o,
    output logic                sa_en_o,
    output logic [N*N*DW-1:0]   sa_w_o,
    output logic [N*DW-1:0]     sa_in_o,
    input  logic [N*AW-1:0]     sa_out_i,
    output logic                irq_o
);
    localparam int NW   = N * N * DW;
    localparam int NR   = N * N;
    localparam int WREQ = (NW + 31) / 32;
    localparam int IW   = $clog2(NW);
    localparam int KW   = (NR > 1) ? $clog2(NR) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(2 * N);

    localparam logic [31:0]   C_WIN      = 32'(16 + 4 * NR);
    localparam logic [7:0]    C_WREQ     = 8'(WREQ);
    localparam logic [7:0]    C_DEPTH    = 8'(FIFO_DEPTH);
    localparam logic [7:0]    C_N        = 8'(N);
    localparam logic [CW-1:0] C_LAST_RUN = CW'(N - 1);
    localparam logic [CW-1:0] C_LAST     = CW'(2 * N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_c;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_sa_en;
    logic [N*DW-1:0]   r_sa_in;
    logic [NW-1:0]     r_wflat;
    logic [7:0]        r_wcnt;
    logic [7:0]        r_lvl;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [N*DW-1:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0]     r_res  [NR];
    logic              r_done;
    logic              r_ovf;
    logic              r_serr;
    logic              r_werr;
    logic              r_irq_en;

    logic [31:0] w_off;
    logic [29:0] w_widx;
    logic [29:0] w_k;
    logic [KW-1:0] w_kidx;
    logic        w_hit, w_acc, w_wr;
    logic        w_ctrl_wr, w_wt_wr, w_in_wr;
    logic        w_start, w_clr, w_busy, w_full, w_push, w_ok, w_go, w_pop;
    logic [31:0] w_rdata;
    logic        w_unused_sel;

    assign w_unused_sel = ^caravel_wb_sel_i;

    assign w_off  = caravel_wb_adr_i - BASE_ADDRESS;
    assign w_widx = w_off[31:2];
    assign w_hit  = caravel_wb_stb_i && caravel_wb_cyc_i &&
                    (caravel_wb_adr_i >= BASE_ADDRESS) && (w_off < C_WIN);
    // A held request is accepted only when no ack is in flight: one ack per two cycles.
    assign w_acc  = w_hit && !r_ack;
    assign w_wr   = w_acc && caravel_wb_we_i;

    assign w_ctrl_wr = w_wr && (w_widx == 30'd0);
    assign w_wt_wr   = w_wr && (w_widx == 30'd2);
    assign w_in_wr   = w_wr && (w_widx == 30'd3);
    assign w_start   = w_ctrl_wr && caravel_wb_dat_i[0];
    assign w_clr     = w_ctrl_wr && caravel_wb_dat_i[1];
    assign w_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_full    = (r_lvl == C_DEPTH);
    assign w_push    = w_in_wr && !w_full && !w_clr;
    assign w_ok      = (r_wcnt == C_WREQ) && (r_lvl >= C_N);
    assign w_go      = w_start && !w_clr && !w_busy && w_ok;
    // The first row is popped on the start edge so sa_in_o is valid during c=0.
    assign w_pop     = w_go || ((r_state == S_RUN) && (r_c != C_LAST_RUN));

    assign w_k    = w_widx - 30'd4;
    assign w_kidx = w_k[KW-1:0];

    always_comb begin
        w_rdata = '0;
        if (w_widx == 30'd1) begin
            w_rdata = {8'h00, r_wcnt, r_lvl, 1'b0, r_werr, r_serr, r_ovf, r_done, r_state};
        end else if ((w_widx >= 30'd4) && (w_k < 30'(NR))) begin
            w_rdata = 32'(r_res[w_kidx]);
        end
    end

    always_ff @(posedge caravel_wb_clk_i) begin
        if (w_push) begin
            r_fifo[r_wp] <= caravel_wb_dat_i[N*DW-1:0];
        end
    end

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
        if (!caravel_wb_rst_n_i) begin
            r_state  <= S_IDLE;
            r_c      <= '0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_sa_en  <= 1'b0;
            r_sa_in  <= '0;
            r_wflat  <= '0;
            r_wcnt   <= '0;
            r_lvl    <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_serr   <= 1'b0;
            r_werr   <= 1'b0;
            r_irq_en <= 1'b0;
            for (int i = 0; i < NR; i++) r_res[i] <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !caravel_wb_we_i) ? w_rdata : '0;

            if (w_wt_wr) begin
                if (w_busy || (r_wcnt == C_WREQ)) begin
                    r_werr <= 1'b1;
                end else begin
                    for (int b = 0; b < 32; b++) begin
                        if (int'(r_wcnt) * 32 + b < NW)
                            r_wflat[IW'(int'(r_wcnt) * 32 + b)] <= caravel_wb_dat_i[b];
                    end
                    r_wcnt <= r_wcnt + 8'd1;
                end
            end

            if (w_in_wr && w_full) r_ovf <= 1'b1;
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_lvl <= r_lvl + 8'(w_push) - 8'(w_pop);
            if (w_ctrl_wr) r_irq_en <= caravel_wb_dat_i[2];

            // Lane j carries the partial sum for output column k at cycle c = j+1+k.
            if (w_busy) begin
                for (int j = 0; j < N; j++) begin
                    if ((int'(r_c) >= j + 1) && (int'(r_c) <= j + N))
                        r_res[KW'(j * N + int'(r_c) - j - 1)] <= sa_out_i[j*AW +: AW];
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        if (w_ok) begin
                            r_state <= S_RUN;
                            r_c     <= '0;
                            r_done  <= 1'b0;
                            r_sa_en <= 1'b1;
                            r_sa_in <= r_fifo[r_rp];
                        end else begin
                            r_serr <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_c <= r_c + CW'(1);
                    if (r_c == C_LAST_RUN) begin
                        r_state <= S_DRAIN;
                        r_sa_in <= '0;
                    end else begin
                        r_sa_in <= r_fifo[r_rp];
                    end
                end
                S_DRAIN: begin
                    if (r_c == C_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_sa_en <= 1'b0;
                    end else begin
                        r_c <= r_c + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_clr) begin
                r_state <= S_IDLE;
                r_c     <= '0;
                r_sa_en <= 1'b0;
                r_sa_in <= '0;
                r_wcnt  <= '0;
                r_lvl   <= '0;
                r_wp    <= '0;
                r_rp    <= '0;
                r_done  <= 1'b0;
                r_ovf   <= 1'b0;
                r_serr  <= 1'b0;
                r_werr  <= 1'b0;
                for (int i = 0; i < NR; i++) r_res[i] <= '0;
            end
        end
    end

    assign caravel_wb_ack_o = r_ack;
    assign caravel_wb_dat_o = r_dat;
    assign sa_en_o          = r_sa_en;
    assign sa_in_o          = r_sa_in;
    assign sa_w_o           = r_wflat;
    assign irq_o            = r_done && r_irq_en;

endmodule

`default_nettype wire
